stage_ex_muldiv: RTL

- Execute-stage pipeline register of the 5-stage pipelined MIPS CPU. It sits between decode and the memory-access stage and produces the ex_* bus that the memory stage latches.
- Registers the ALU result and control fields from decode.
- Owns the HI/LO registers and an iterative 32-cycle multiply/divide unit (MDU). The MDU runs in the background; a hazard interlock stalls decode only when a later HI/LO or MDU instruction arrives while the MDU is busy.

---
 rtl/stage_ex_muldiv.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/stage_ex_muldiv.sv
// Execute-stage pipeline register with HI/LO and a 32-cycle iterative multiply/divide unit.
// Ports: clk/rst, id_* decode bundle in, ex_* registered bus out, ex_stall (comb), md_busy.
module stage_ex_muldiv #(
   parameter int RF_SRC_W  = 2,
   parameter int MD_CYCLES = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         id_aluResult,
   input  logic [31:0]         id_opA,
   input  logic [31:0]         id_opB,
   input  logic [3:0]          id_mdOp,
   input  logic [31:0]         id_memData,
   input  logic                id_memWE,
   input  logic                id_rfWE,
   input  logic [4:0]          id_rfDst,
   input  logic [RF_SRC_W-1:0] id_rfSrc,
   output logic                ex_stall,
   output logic [31:0]         ex_opResult,
   output logic [31:0]         ex_memData,
   output logic                ex_memWE,
   output logic                ex_rfWE,
   output logic [4:0]          ex_rfDst,
   output logic [RF_SRC_W-1:0] ex_rfSrc,
   output logic                md_busy
);

   localparam int CNT_W = $clog2(MD_CYCLES);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi, lo;
   logic [31:0]      p_hi, p_lo;
   logic [31:0]      b_mag, a_raw;
   logic             is_div, neg_res, neg_rem, div_zero;

   logic             md_type, md_start, op_signed, op_div;
   logic [31:0]      a_abs, b_abs, res_sel;
   logic [32:0]      mul_sum, div_sh, div_tr;
   logic [31:0]      nxt_hi, nxt_lo, fin_hi, fin_lo;
   logic [63:0]      prod, prod_fix;

   assign md_type   = (id_mdOp >= OP_MULT) && (id_mdOp <= OP_MTLO);
   assign ex_stall  = md_busy & md_type;
   assign md_start  = !ex_stall && (id_mdOp >= OP_MULT) && (id_mdOp <= OP_DIVU);
   assign op_signed = (id_mdOp == OP_MULT) || (id_mdOp == OP_DIV);
   assign op_div    = (id_mdOp == OP_DIV) || (id_mdOp == OP_DIVU);
   assign a_abs     = (op_signed && id_opA[31]) ? -id_opA : id_opA;
   assign b_abs     = (op_signed && id_opB[31]) ? -id_opB : id_opB;

   // One iteration. Multiply: {p_hi,p_lo} is {partial product, multiplier},
   // shifted right each step. Divide: p_hi is the partial remainder and p_lo
   // shifts the dividend out while the quotient bits shift in.
   assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag} : 33'd0);
   assign div_sh  = {p_hi, p_lo[31]};
   assign div_tr  = div_sh - {1'b0, b_mag};

   always_comb begin
      nxt_hi = mul_sum[32:1];
      nxt_lo = {mul_sum[0], p_lo[31:1]};
      if (is_div) begin
         if (!div_tr[32]) begin
            nxt_hi = div_tr[31:0];
            nxt_lo = {p_lo[30:0], 1'b1};
         end else begin
            nxt_hi = div_sh[31:0];
            nxt_lo = {p_lo[30:0], 1'b0};
         end
      end
   end

   // Sign fix-up applied on the final iteration. Divide by zero bypasses
   // the datapath so the result is independent of operand signs.
   always_comb begin
      prod     = {nxt_hi, nxt_lo};
      prod_fix = neg_res ? -prod : prod;
      fin_hi   = prod_fix[63:32];
      fin_lo   = prod_fix[31:0];
      if (is_div) begin
         if (div_zero) begin
            fin_hi = a_raw;
            fin_lo = 32'hFFFF_FFFF;
         end else begin
            fin_hi = neg_rem ? -nxt_hi : nxt_hi;
            fin_lo = neg_res ? -nxt_lo : nxt_lo;
         end
      end
   end

   always_comb begin
      res_sel = id_aluResult;
      if (id_mdOp == OP_MFHI) res_sel = hi;
      else if (id_mdOp == OP_MFLO) res_sel = lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_opResult <= '0;
         ex_memData  <= '0;
         ex_memWE    <= 1'b0;
         ex_rfWE     <= 1'b0;
         ex_rfDst    <= '0;
         ex_rfSrc    <= '0;
         state       <= S_IDLE;
         md_busy     <= 1'b0;
         cnt         <= '0;
         hi          <= '0;
         lo          <= '0;
         p_hi        <= '0;
         p_lo        <= '0;
         b_mag       <= '0;
         a_raw       <= '0;
         is_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         div_zero    <= 1'b0;
      end else begin
         if (ex_stall) begin
            ex_opResult <= '0;
            ex_memData  <= '0;
            ex_memWE    <= 1'b0;
            ex_rfWE     <= 1'b0;
            ex_rfDst    <= '0;
            ex_rfSrc    <= '0;
         end else begin
            ex_opResult <= res_sel;
            ex_memData  <= id_memData;
            ex_memWE    <= id_memWE;
            ex_rfWE     <= id_rfWE;
            ex_rfDst    <= id_rfDst;
            ex_rfSrc    <= id_rfSrc;
         end

         case (state)
            S_IDLE: begin
               md_busy <= 1'b0;
               if (md_start) begin
                  state    <= S_BUSY;
                  md_busy  <= 1'b1;
                  cnt      <= '0;
                  p_hi     <= '0;
                  p_lo     <= a_abs;
                  b_mag    <= b_abs;
                  a_raw    <= id_opA;
                  is_div   <= op_div;
                  neg_res  <= op_signed & (id_opA[31] ^ id_opB[31]);
                  neg_rem  <= op_signed & id_opA[31];
                  div_zero <= op_div & (id_opB == 32'd0);
               end
            end
            S_BUSY: begin
               p_hi <= nxt_hi;
               p_lo <= nxt_lo;
               if (cnt == CNT_W'(MD_CYCLES - 1)) begin
                  hi      <= fin_hi;
                  lo      <= fin_lo;
                  state   <= S_IDLE;
                  md_busy <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               md_busy <= 1'b0;
            end
         endcase

         // MTHI/MTLO only reach here when the MDU is idle, so they never
         // collide with the final HI/LO write above.
         if (!ex_stall && id_mdOp == OP_MTHI) hi <= id_opA;
         if (!ex_stall && id_mdOp == OP_MTLO) lo <= id_opA;
      end
   end

endmodule
